// File: rtl/mem_stream_writer.sv
// Byte stream to 32-bit little-endian words, written into a ring in on-chip memory; one write 1 cycle after the flushing byte.
// snk_ready drops when the ring is full or the writer is not running; MEM_STREAM_WRITER_IRQ_EN adds an eop interrupt.
module mem_stream_writer #(
   parameter int BASE  = 0,
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  snk_data,
   input  logic        snk_valid,
   input  logic        snk_eop,
   output logic        snk_ready,
   output logic [10:0] mem_address,
   output logic [3:0]  mem_byteenable,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [1:0]  ctl_address,
   input  logic        ctl_read,
   input  logic        ctl_write,
   input  logic [31:0] ctl_writedata,
`ifdef MEM_STREAM_WRITER_IRQ_EN
   output logic        irq,
`endif
   output logic [31:0] ctl_readdata
);

   typedef enum logic [1:0] {S_DISABLED, S_RUN, S_DRAIN} state_t;

   localparam logic [10:0] LAST    = 11'(DEPTH - 1);
   localparam logic [10:0] BASE_A  = 11'(BASE);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t      state_q, state_d;
   logic        enable_q, enable_d;
   logic [10:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_nxt;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] acc_data_q, acc_data_d, pack_data;
   logic [3:0]  acc_be_q, acc_be_d, pack_be;
   logic        mem_write_q, mem_write_d;
   logic [10:0] mem_address_q, mem_address_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic [31:0] rdata_q, rdata_d;
   logic        full, empty, busy, accept, flush, ctrl_wr, clear, rd_wr, stat_wr;
   logic        irq_en_rd, irq_pend_rd;
`ifdef MEM_STREAM_WRITER_IRQ_EN
   logic        irq_en_q, irq_en_d, irq_q, irq_d;
`endif

   assign wr_nxt    = (wr_ptr_q == LAST) ? 11'd0 : wr_ptr_q + 11'd1;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_nxt == rd_ptr_q);
   assign busy      = (state_q == S_DRAIN) | (lane_q != 2'd0);
   assign snk_ready = (state_q == S_RUN) & ~full;
   assign accept    = snk_valid & snk_ready;
   assign flush     = accept & ((lane_q == 2'd3) | snk_eop);
   assign ctrl_wr   = ctl_write & (ctl_address == 2'd0);
   assign clear     = ctrl_wr & ctl_writedata[1];
   assign rd_wr     = ctl_write & (ctl_address == 2'd2);
   assign stat_wr   = ctl_write & (ctl_address == 2'd3);

   always_comb begin
      pack_data = acc_data_q;
      pack_data[{lane_q, 3'b000} +: 8] = snk_data;
      pack_be = acc_be_q | (4'b0001 << lane_q);
   end

   always_comb begin
      state_d       = state_q;
      enable_d      = ctrl_wr ? ctl_writedata[0] : enable_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_wr ? 11'(ctl_writedata % DEPTH_W) : rd_ptr_q;
      pkt_cnt_d     = pkt_cnt_q;
      lane_d        = lane_q;
      acc_data_d    = acc_data_q;
      acc_be_d      = acc_be_q;
      mem_write_d   = 1'b0;
      mem_address_d = mem_address_q;
      mem_be_d      = mem_be_q;
      mem_data_d    = mem_data_q;
      case (state_q)
         S_DISABLED: if (enable_q) state_d = S_RUN;
         S_RUN: begin
            if (flush) begin
               mem_write_d   = 1'b1;
               mem_address_d = BASE_A + wr_ptr_q;
               mem_be_d      = pack_be;
               mem_data_d    = pack_data;
               wr_ptr_d      = wr_nxt;
               lane_d        = 2'd0;
               acc_data_d    = 32'd0;
               acc_be_d      = 4'd0;
               if (snk_eop) pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else if (accept) begin
               lane_d     = lane_q + 2'd1;
               acc_data_d = pack_data;
               acc_be_d   = pack_be;
            end
            // A byte taken in the same cycle enable drops still gets drained.
            if (!enable_d) state_d = (lane_d != 2'd0) ? S_DRAIN : S_DISABLED;
         end
         S_DRAIN: begin
            mem_write_d   = 1'b1;
            mem_address_d = BASE_A + wr_ptr_q;
            mem_be_d      = acc_be_q;
            mem_data_d    = acc_data_q;
            wr_ptr_d      = wr_nxt;
            lane_d        = 2'd0;
            acc_data_d    = 32'd0;
            acc_be_d      = 4'd0;
            state_d       = S_DISABLED;
         end
         default: state_d = S_DISABLED;
      endcase
      if (clear) begin
         state_d       = S_DISABLED;
         enable_d      = 1'b0;
         wr_ptr_d      = 11'd0;
         rd_ptr_d      = 11'd0;
         pkt_cnt_d     = 16'd0;
         lane_d        = 2'd0;
         acc_data_d    = 32'd0;
         acc_be_d      = 4'd0;
         mem_write_d   = 1'b0;
         mem_address_d = mem_address_q;
         mem_be_d      = mem_be_q;
         mem_data_d    = mem_data_q;
      end
   end

`ifdef MEM_STREAM_WRITER_IRQ_EN
   always_comb begin
      irq_en_d = ctrl_wr ? ctl_writedata[2] : irq_en_q;
      irq_d    = (irq_q & ~(stat_wr & ctl_writedata[3])) | (flush & snk_eop & irq_en_q);
      if (clear) irq_d = 1'b0;
   end
   assign irq_en_rd   = irq_en_q;
   assign irq_pend_rd = irq_q;
   assign irq         = irq_q;
`else
   assign irq_en_rd   = 1'b0;
   assign irq_pend_rd = 1'b0;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (ctl_read) begin
         case (ctl_address)
            2'd0:    rdata_d = {29'd0, irq_en_rd, 1'b0, enable_q};
            2'd1:    rdata_d = {21'd0, wr_ptr_q};
            2'd2:    rdata_d = {21'd0, rd_ptr_q};
            default: rdata_d = {pkt_cnt_q, 12'd0, irq_pend_rd, busy, full, empty};
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_DISABLED;
         enable_q      <= 1'b0;
         wr_ptr_q      <= 11'd0;
         rd_ptr_q      <= 11'd0;
         pkt_cnt_q     <= 16'd0;
         lane_q        <= 2'd0;
         acc_data_q    <= 32'd0;
         acc_be_q      <= 4'd0;
         mem_write_q   <= 1'b0;
         mem_address_q <= 11'd0;
         mem_be_q      <= 4'd0;
         mem_data_q    <= 32'd0;
         rdata_q       <= 32'd0;
`ifdef MEM_STREAM_WRITER_IRQ_EN
         irq_en_q      <= 1'b0;
         irq_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         enable_q      <= enable_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         pkt_cnt_q     <= pkt_cnt_d;
         lane_q        <= lane_d;
         acc_data_q    <= acc_data_d;
         acc_be_q      <= acc_be_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_be_q      <= mem_be_d;
         mem_data_q    <= mem_data_d;
         rdata_q       <= rdata_d;
`ifdef MEM_STREAM_WRITER_IRQ_EN
         irq_en_q      <= irq_en_d;
         irq_q         <= irq_d;
`endif
      end
   end

   assign mem_write      = mem_write_q;
   assign mem_chipselect = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_byteenable = mem_be_q;
   assign mem_writedata  = mem_data_q;
   assign ctl_readdata   = rdata_q;

endmodule
